// File: rtl/wishbone_board_ram_if.sv
// Shared Wishbone bus between the team's master and the board-state RAM.
// Carries an 8-bit address, 8-bit data, single-request handshake and stall.
interface wishbone_if;
   logic [7:0] adr_i;
   logic [7:0] dat_i;
   logic       we_i;
   logic       stb_i;
   logic       cyc_i;
   logic [7:0] dat_o;
   logic       ack_o;
   logic       stall_o;

   modport slave  (input  adr_i, dat_i, we_i, stb_i, cyc_i,
                   output dat_o, ack_o, stall_o);
   modport master (output adr_i, dat_i, we_i, stb_i, cyc_i,
                   input  dat_o, ack_o, stall_o);
endinterface

// File: rtl/wishbone_board_ram.sv
// Wishbone slave holding the 8-bit board state; one ack per request after WAIT_CYCLES wait states.
// Define BOARD_RAM_CLEAR_EN to zero the whole array after every reset before serving requests.
module wishbone_board_ram #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 0
) (
   input logic       clk,
   input logic       rst,
   wishbone_if.slave wb_slave
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef BOARD_RAM_CLEAR_EN
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_CLEAR} state_t;
   localparam state_t RESET_STATE = S_CLEAR;
   localparam logic   RESET_STALL = 1'b1;
   logic [7:0] clr_adr, clr_adr_d;
`else
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
   localparam state_t RESET_STATE = S_IDLE;
   localparam logic   RESET_STALL = 1'b0;
`endif

   state_t     state, state_d;
   logic [3:0] wait_cnt, wait_cnt_d;
   logic [7:0] adr_q, dat_q;
   logic       we_q;
   logic       ack_q, stall_q, stall_d;
   logic [7:0] rdat_q;
   logic       accept, access;
   logic [7:0] acc_adr, acc_dat;
   logic       acc_we, acc_in_range;
   logic       mem_wr;
   logic [7:0] mem_wr_adr, mem_wr_dat;
   logic [7:0] mem [DEPTH];

   // NOTE: every signal gets a default at the top so no path through the case leaves one unassigned (no latches).
   always_comb begin
      state_d    = state;
      wait_cnt_d = wait_cnt;
      accept     = 1'b0;
      access     = 1'b0;
      acc_adr    = adr_q;
      acc_dat    = dat_q;
      acc_we     = we_q;
`ifdef BOARD_RAM_CLEAR_EN
      clr_adr_d  = clr_adr;
`endif
      case (state)
         S_IDLE: begin
            // With zero wait states the access happens on the accepting edge, so use the live bus.
            acc_adr = wb_slave.adr_i;
            acc_dat = wb_slave.dat_i;
            acc_we  = wb_slave.we_i;
            if (wb_slave.stb_i && wb_slave.cyc_i && !ack_q) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_d = S_ACK;
                  access  = 1'b1;
               end else begin
                  state_d    = S_WAIT;
                  wait_cnt_d = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         S_WAIT: begin
            if (!wb_slave.cyc_i) begin
               state_d = S_IDLE;
            end else if (wait_cnt == 4'd0) begin
               state_d = S_ACK;
               access  = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt - 4'd1;
            end
         end
         S_ACK: state_d = S_IDLE;
`ifdef BOARD_RAM_CLEAR_EN
         S_CLEAR: begin
            clr_adr_d = clr_adr + 8'd1;
            if (clr_adr == 8'(DEPTH - 1)) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      acc_in_range = int'(acc_adr) < DEPTH;
      mem_wr       = access && acc_we && acc_in_range;
      mem_wr_adr   = acc_adr;
      mem_wr_dat   = acc_dat;
      stall_d      = (state_d == S_WAIT);
`ifdef BOARD_RAM_CLEAR_EN
      if (state == S_CLEAR) begin
         mem_wr     = 1'b1;
         mem_wr_adr = clr_adr;
         mem_wr_dat = 8'h00;
      end
      stall_d = stall_d || (state_d == S_CLEAR);
`endif
   end

   // NOTE: the array has no reset branch on purpose; board contents must survive rst, only writes are blocked.
   always_ff @(posedge clk) begin
      if (!rst && mem_wr) mem[mem_wr_adr[AW-1:0]] <= mem_wr_dat;
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RESET_STATE;
         wait_cnt <= 4'd0;
         ack_q    <= 1'b0;
         stall_q  <= RESET_STALL;
         rdat_q   <= 8'h00;
         adr_q    <= 8'h00;
         dat_q    <= 8'h00;
         we_q     <= 1'b0;
`ifdef BOARD_RAM_CLEAR_EN
         clr_adr  <= 8'h00;
`endif
      end else begin
         state    <= state_d;
         wait_cnt <= wait_cnt_d;
         ack_q    <= (state_d == S_ACK);
         stall_q  <= stall_d;
`ifdef BOARD_RAM_CLEAR_EN
         clr_adr  <= clr_adr_d;
`endif
         if (accept) begin
            adr_q <= wb_slave.adr_i;
            dat_q <= wb_slave.dat_i;
            we_q  <= wb_slave.we_i;
         end
         // Reads past DEPTH return zero; dat_o is otherwise held until the next read completes.
         if (access && !acc_we) rdat_q <= acc_in_range ? mem[acc_adr[AW-1:0]] : 8'h00;
      end
   end

   assign wb_slave.dat_o   = rdat_q;
   assign wb_slave.ack_o   = ack_q;
   assign wb_slave.stall_o = stall_q;
endmodule

// File: tb/tb_wishbone_board_ram.sv
// Directed bench: three RAM instances (0 waits, 3 waits, DEPTH 200) driven in one linear sequence.
// Also covers the sweep behaviour when built with BOARD_RAM_CLEAR_EN.
module tb_wishbone_board_ram;
   localparam int DEPTH_P [3] = '{256, 256, 200};
   localparam int WAIT_P  [3] = '{0, 3, 0};
`ifdef BOARD_RAM_CLEAR_EN
   localparam logic       EXP_RST_STALL = 1'b1;
   localparam logic [7:0] EXP_ADR20     = 8'h00;
`else
   localparam logic       EXP_RST_STALL = 1'b0;
   localparam logic [7:0] EXP_ADR20     = 8'h11;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [7:0] adr [3];
   logic [7:0] wdat [3];
   logic       we [3];
   logic       stb [3];
   logic       cyc [3];
   logic [7:0] rdat [3];
   logic       ack [3];
   logic       stall [3];
   int         ack_cnt [3] = '{0, 0, 0};
   int         vectors = 0;
   int         miscompares = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      wishbone_if bus ();
      assign bus.adr_i = adr[g];
      assign bus.dat_i = wdat[g];
      assign bus.we_i  = we[g];
      assign bus.stb_i = stb[g];
      assign bus.cyc_i = cyc[g];
      assign rdat[g]   = bus.dat_o;
      assign ack[g]    = bus.ack_o;
      assign stall[g]  = bus.stall_o;
      wishbone_board_ram #(.DEPTH(DEPTH_P[g]), .WAIT_CYCLES(WAIT_P[g])) dut (
         .clk      (clk),
         .rst      (rst),
         .wb_slave (bus)
      );
   end

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) if (ack[k] === 1'b1) ack_cnt[k] <= ack_cnt[k] + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 400 && (stall[0] || stall[1] || stall[2]); i++) begin
         @(posedge clk); #1;
      end
      check("ready", {29'd0, stall[0], stall[1], stall[2]}, 32'd0);
   endtask

   // One master request; holds stb one extra cycle after ack like the real master does.
   task automatic req(input string tag, input int k, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input int abort_at, output logic got,
                      output int lat, output int stalls, output logic [7:0] rd);
      int limit;
      got = 1'b0; lat = 0; stalls = 0; rd = 8'h00; limit = 400;
      adr[k] = a; wdat[k] = d; we[k] = w; stb[k] = 1'b1; cyc[k] = 1'b1;
      while (!got && lat < limit) begin
         @(posedge clk); #1;
         lat++;
         if (ack[k]) begin
            got = 1'b1;
            rd  = rdat[k];
            check({tag, "_stall_at_ack"}, 32'(stall[k]), 32'd0);
         end else if (stall[k]) begin
            stalls++;
         end
         if (lat == abort_at) begin
            stb[k] = 1'b0; cyc[k] = 1'b0;
            limit  = lat + 6;
         end
      end
      if (got) begin
         @(posedge clk); #1;
         check({tag, "_single_ack"}, 32'(ack[k]), 32'd0);
         stb[k] = 1'b0; cyc[k] = 1'b0;
         @(posedge clk); #1;
         check({tag, "_no_retrigger"}, 32'(ack[k]), 32'd0);
      end
      stb[k] = 1'b0; cyc[k] = 1'b0;
   endtask

   task automatic xfer(input string tag, input int k, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input int exp_lat, input logic [7:0] exp_rd);
      logic       got;
      int         lat, stalls;
      logic [7:0] rd;
      req(tag, k, w, a, d, 0, got, lat, stalls, rd);
      check({tag, "_ack"}, 32'(got), 32'd1);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_stalls"}, 32'(stalls), 32'(exp_lat - 1));
      check({tag, "_dat_o"}, 32'(rd), 32'(exp_rd));
   endtask

   initial begin
      logic       got;
      int         lat, stalls, clr_stalls;
      logic [7:0] rd;

      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         adr[k] = 8'h00; wdat[k] = 8'h00; we[k] = 1'b0; stb[k] = 1'b0; cyc[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset_ack%0d", k), 32'(ack[k]), 32'd0);
         check($sformatf("reset_stall%0d", k), 32'(stall[k]), 32'(EXP_RST_STALL));
         check($sformatf("reset_dat%0d", k), 32'(rdat[k]), 32'd0);
      end
      rst = 1'b0;
      wait_ready();

      // Zero wait states: ack one cycle after the request is sampled.
      xfer("w0_wr12", 0, 1'b1, 8'h12, 8'hA5, 1, 8'h00);
      xfer("w0_rd12", 0, 1'b0, 8'h12, 8'h00, 1, 8'hA5);
      check("w0_ack_count", 32'(ack_cnt[0]), 32'd2);

      // Three wait states: three stall cycles, ack in the fourth.
      xfer("w3_wr12", 1, 1'b1, 8'h12, 8'h42, 4, 8'h00);
      xfer("w3_rd12", 1, 1'b0, 8'h12, 8'h00, 4, 8'h42);

      // DEPTH 200: 0xC8 is out of range and must not alias onto 0x48.
      xfer("d200_wr48", 2, 1'b1, 8'h48, 8'h6B, 1, 8'h00);
      xfer("d200_rd48", 2, 1'b0, 8'h48, 8'h00, 1, 8'h6B);
      xfer("d200_wrC8", 2, 1'b1, 8'hC8, 8'h77, 1, 8'h6B);
      xfer("d200_rdC8", 2, 1'b0, 8'hC8, 8'h00, 1, 8'h00);
      xfer("d200_rd48b", 2, 1'b0, 8'h48, 8'h00, 1, 8'h6B);
      check("d200_ack_count", 32'(ack_cnt[2]), 32'd5);

      // Abort: cyc dropped during the second wait cycle discards the write.
      xfer("w3_wr05", 1, 1'b1, 8'h05, 8'h5A, 4, 8'h42);
      req("w3_abort", 1, 1'b1, 8'h05, 8'h3C, 2, got, lat, stalls, rd);
      check("w3_abort_no_ack", 32'(got), 32'd0);
      check("w3_abort_idle_stall", 32'(stall[1]), 32'd0);
      check("w3_abort_ack_count", 32'(ack_cnt[1]), 32'd3);
      xfer("w3_rd05", 1, 1'b0, 8'h05, 8'h00, 4, 8'h5A);
      check("w3_ack_count", 32'(ack_cnt[1]), 32'd4);

      // Reset during the ACK cycle; the write was already committed when ACK was entered.
      xfer("w0_wr20", 0, 1'b1, 8'h20, 8'h33, 1, 8'hA5);
      adr[0] = 8'h20; wdat[0] = 8'h11; we[0] = 1'b1; stb[0] = 1'b1; cyc[0] = 1'b1;
      @(posedge clk); #1;
      check("rstack_ack_seen", 32'(ack[0]), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rstack_ack_cleared", 32'(ack[0]), 32'd0);
      check("rstack_stall", 32'(stall[0]), 32'(EXP_RST_STALL));
      check("rstack_dat", 32'(rdat[0]), 32'd0);
      rst = 1'b0; stb[0] = 1'b0; cyc[0] = 1'b0;
      wait_ready();
      xfer("w0_rd20", 0, 1'b0, 8'h20, 8'h00, 1, EXP_ADR20);

`ifdef BOARD_RAM_CLEAR_EN
      // Sweep after reset: stall for exactly DEPTH cycles, a read held through it sees zero.
      xfer("clr_preload", 0, 1'b1, 8'hFF, 8'hFF, 1, 8'h00);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      clr_stalls = int'(stall[0]);
      repeat (99) begin
         @(posedge clk); #1;
         clr_stalls += int'(stall[0]);
      end
      req("clr_rdFF", 0, 1'b0, 8'hFF, 8'h00, 0, got, lat, stalls, rd);
      check("clr_rd_ack", 32'(got), 32'd1);
      check("clr_stall_cycles", 32'(clr_stalls + stalls), 32'd256);
      check("clr_rd_data", 32'(rd), 32'd0);
      check("w0_ack_count", 32'(ack_cnt[0]), 32'd7);
`else
      check("w0_ack_count", 32'(ack_cnt[0]), 32'd5);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
